matrix_stream_loader: RTL
=========================

# matrix_stream_loader

Streaming front/back end for the 4×4 8-bit matrix multiplier. Accepts A and B as a byte stream over a valid/ready port and assembles them into the multiplier's flat operand buses. It then issues the single-cycle `opcode` start, tracks `busy_M` to completion, and streams the 16-bit product elements back out over a second valid/ready port. It sits directly upstream of the multiplier's `in_A`/`in_B`/`opcode` and downstream of its `out_M`/`busy_M`.

## Interface
- `row`, default 4: matrix rows; must match the multiplier.
- `col`, default 4: matrix columns; must match the multiplier.
- `clk`, input, 1: single clock; all state on rising edge.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input byte valid.
- `in_data`, input, 8: input byte; A elements first, then B, each row-major.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `out_A`, output, 8*row*col: to multiplier `in_A`; element [i][j] at bits [(i*col+j)*8 +: 8].
- `out_B`, output, 8*row*col: to multiplier `in_B`; same layout as `out_A`.
- `opcode`, output, 1: start pulse to the multiplier.
- `busy_M`, input, 1: multiplier busy.
- `in_M`, input, 16*row*col: from multiplier `out_M`; element k at bits [k*16 +: 16].
- `out_valid`, output, 1: result element valid.
- `out_data`, output, 16: result element, row-major.
- `out_last`, output, 1: marks the final element, k = row*col-1.
- `busy_L`, output, 1: a transaction is in progress.

## Operation
- FSM states: `LOAD_A`, `LOAD_B`, `START`, `WAIT_HI`, `WAIT_LO`, `UNLOAD`. Element index counter `idx` runs 0..row*col-1 and is $clog2(row*col)+1 bits wide.
- `LOAD_A`:
  - `in_ready`=1.
  - On `in_valid && in_ready`, write `in_data` to A element `idx` and set `idx` to `idx`+1.
  - On the accept at `idx`=row*col-1: set `idx` to 0 and go to `LOAD_B`.
- `LOAD_B`: same behaviour, writing B. The last accept goes to `START`.
- `START`: `opcode`=1 for exactly this one cycle; then go to `WAIT_HI`.
- `WAIT_HI`: stay until `busy_M`=1, then go to `WAIT_LO`. There is no timeout.
- `WAIT_LO`: stay until `busy_M`=0, then set `idx` to 0 and go to `UNLOAD`.
- `UNLOAD`:
  - `out_valid`=1.
  - `out_data` = `in_M`[idx*16 +: 16].
  - `out_last` = (`idx`==row*col-1).
  - On `out_valid && out_ready`, set `idx` to `idx`+1. The accept with `out_last` returns the FSM to `LOAD_A` with `idx`=0.
- A/B operand registers hold their values until overwritten byte-by-byte by the next load. They are never cleared except by reset.
- `busy_L` = 0 only in `LOAD_A` with `idx`=0; otherwise 1.
- The block performs no arithmetic; products pass through unmodified, including any 16-bit wrap done by the multiplier.
- `in_ready`=0 in every state other than `LOAD_A`/`LOAD_B`; bytes offered then are not consumed.
- `out_valid`=0 in every state other than `UNLOAD`. `out_data` is don't-care when `out_valid`=0, but the implementation drives 0.

## Timing
- Reset (asynchronous, any state):
  - State goes to `LOAD_A`, `idx`=0.
  - `out_A`=0, `out_B`=0.
  - `opcode`=0, `out_valid`=0, `out_last`=0, `busy_L`=0.
  - `in_ready`=1 from the first cycle after release.
- Reset mid-transaction discards all progress. The multiplier is reset by the same net, so no stale `busy_M` handling is required.
- Load takes one cycle per byte with no bubbles; 32 cycles minimum for 4×4. `in_valid` gaps only stall.
- Last B byte accepted at cycle t:
  - `out_B` is updated at t+1, the same cycle `opcode`=1. Operands are therefore stable while `opcode` is high.
  - `busy_M` rises at t+2 and the FSM leaves `WAIT_HI` at t+3.
- `busy_M` stays high for row*col*(col+1) cycles (80 for 4×4).
- The first `out_valid` appears in the cycle after the FSM samples `busy_M`=0 in `WAIT_LO`.
- Unload: one element per cycle when `out_ready`=1. `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- The next transaction's first byte can be accepted in the cycle after the final unload handshake.
- `opcode` is never high for more than one cycle and is never asserted outside `START`.

## Test plan
- A = identity, B = bytes 0x01..0x10 row-major, `out_ready`=1:
  - Expect 16 outputs 0x0001..0x0010 in order, with `out_last` only on the 16th.
  - Expect exactly one `opcode` pulse.
- A = all 0x02, B = all 0x03: expect every output = 0x0018. A second back-to-back transaction with A = 0, any B: expect all outputs = 0x0000.
- A = B = all 0xFF: expect every output = 0xF804 (4×0xFE01 truncated to 16 bits).
- Random `in_valid` gaps and random `out_ready` deassertion:
  - Results must match the reference product.
  - `in_ready`=0 in `START`/`WAIT_*`/`UNLOAD`.
  - `out_data` must hold stable under stall.
- Assert `n_reset` in `WAIT_LO`, and again mid-`UNLOAD` after 5 results:
  - All outputs go to 0, `busy_L`=0.
  - A full new transaction then completes correctly.
- Latency check: with `in_valid`/`out_ready` tied to 1 for a 4×4 transaction, the first `out_valid` must occur at a fixed, repeatable cycle offset from the last B accept. The bench checks it equals 83 ±1 cycles consistently across runs.

Source files
------------

// File: rtl/matrix_stream_loader_if.sv
// Byte-in / element-out streaming port of the matrix stream loader.
// Handshake: a transfer occurs on a rising clk edge where valid && ready are both high;
// the sender keeps data stable while valid is high and ready is low, and ready never depends on valid.
interface matrix_stream_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Loads A and B for the matrix multiplier from a byte stream, starts it, waits for
// busy_M to complete a high/low cycle and streams the 16-bit products back out.
module matrix_stream_loader #(
  parameter int row = 4,
  parameter int col = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  matrix_stream_loader_if.slave    strm,
  output logic [8*row*col-1:0]     out_A,
  output logic [8*row*col-1:0]     out_B,
  output logic                     opcode,
  input  logic                     busy_M,
  input  logic [16*row*col-1:0]    in_M,
  output logic                     busy_L,
  output logic [2:0]               dbg_state
);

  localparam int N  = row * col;
  localparam int IW = $clog2(N) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    UNLOAD  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [8*N-1:0]  a_q, b_q;
  logic            a_we, b_we;
  logic            in_ready_c, out_valid_c, out_last_c;
  logic [15:0]     out_data_c;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    opcode      = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    case (state_q)
      LOAD_A: begin
        in_ready_c = 1'b1;
        if (strm.in_valid) begin
          a_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready_c = 1'b1;
        if (strm.in_valid) begin
          b_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      START: begin
        opcode  = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (busy_M) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!busy_M) begin
          idx_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid_c = 1'b1;
        if (strm.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD_A;
      end
    endcase
  end

  // Operands persist across transactions; only reset or a new byte changes them.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (a_we && idx_q == IW'(k)) a_q[k*8 +: 8] <= strm.in_data;
        if (b_we && idx_q == IW'(k)) b_q[k*8 +: 8] <= strm.in_data;
      end
    end
  end

  always_comb begin
    out_data_c = '0;
    if (state_q == UNLOAD) begin
      for (int k = 0; k < N; k++) begin
        if (idx_q == IW'(k)) out_data_c = in_M[k*16 +: 16];
      end
    end
  end

  assign out_last_c     = (state_q == UNLOAD) && (idx_q == LAST_IDX);
  assign strm.in_ready  = in_ready_c;
  assign strm.out_valid = out_valid_c;
  assign strm.out_data  = out_data_c;
  assign strm.out_last  = out_last_c;
  assign out_A          = a_q;
  assign out_B          = b_q;
  assign busy_L         = !((state_q == LOAD_A) && (idx_q == '0));
  assign dbg_state      = state_q;

endmodule
